mod16_sequence_checker: RTL
===========================

// Module: mod16_sequence_checker
// PURPOSE
//  Receive-side monitor for the free-running Mod-16 counter output.
//  - Samples the count bus, locks onto the +1 mod 2^WIDTH sequence and keeps predicting the next value.
//  - Flags and counts sequence errors; counts wrap-arounds while locked.
//  - Sits downstream of the counter, as a self-check block and as a bench checker.
// PARAMETERS
//  WIDTH       4   count bus width (sequence is mod 2^WIDTH)
//  LOCK_COUNT  2   consecutive in-sequence samples needed to lock (>=1)
//  ERR_LIMIT   3   consecutive mismatches while locked before lock is dropped (>=1)
//  WRAP_W      8   width of wrap_count
// PORTS
//  CLK          in   1       clock, all logic on rising edge
//  RST          in   1       synchronous reset, active-high
//  count_in     in   WIDTH   sampled counter value
//  count_valid  in   1       count_in is valid this cycle
//  clear_stats  in   1       zero wrap_count and error_count
//  locked       out  1       1 in LOCKED or SLIP
//  state        out  2       00 HUNT, 01 SYNC, 10 LOCKED, 11 SLIP
//  expected     out  WIDTH   predicted next count_in
//  error_pulse  out  1       one-cycle pulse per mismatch while locked
//  error_count  out  8       mismatches while locked, saturates at 255
//  wrap_count   out  WRAP_W  matched all-ones samples while locked, wraps mod 2^WRAP_W
// BEHAVIOUR
//  - All outputs are registered. A sample presented in cycle N is reflected after the edge ending cycle N (1-cycle latency).
//  - Reset (RST=1 at an edge, at any time, mid-operation included):
//      state=HUNT, locked=0, expected=0, error_pulse=0, error_count=0, wrap_count=0, internal match_cnt=0, miss_cnt=0.
//  - count_valid=0: state, expected, match_cnt and miss_cnt hold; error_pulse=0.
//  - "match" means count_valid & (count_in == expected). All "+1" below is mod 2^WIDTH (15+1 -> 0 at WIDTH=4).
//  - HUNT, on valid:
//      expected <= count_in+1; match_cnt <= 1.
//      If LOCK_COUNT==1 -> LOCKED, else -> SYNC.
//  - SYNC, on match:
//      expected <= count_in+1; match_cnt++.
//      If the new match_cnt == LOCK_COUNT -> LOCKED.
//  - SYNC, on valid mismatch (reseed, stay in SYNC, no error flagged):
//      expected <= count_in+1; match_cnt <= 1.
//  - LOCKED, on match: expected <= expected+1; miss_cnt <= 0.
//  - LOCKED, on valid mismatch (flywheel):
//      error_pulse=1, error_count++ (saturating), miss_cnt <= 1, expected <= expected+1.
//      If ERR_LIMIT==1 -> HUNT, else -> SLIP.
//  - SLIP, on match: -> LOCKED; miss_cnt <= 0; expected <= expected+1.
//  - SLIP, on valid mismatch:
//      error_pulse=1, error_count++ (saturating), miss_cnt++, expected <= expected+1.
//      If the new miss_cnt == ERR_LIMIT -> HUNT.
//  - On entry to HUNT from SLIP: locked=0, expected holds its last value, error_count is kept.
//  - wrap_count increments on a match in LOCKED or SLIP when count_in is all ones.
//  - clear_stats zeroes error_count and wrap_count.
//      If it coincides with an increment, clear wins and the result is 0. State and lock are unaffected.
//  - error_pulse is never asserted in HUNT or SYNC.
// TESTING (WIDTH=4, LOCK_COUNT=2, ERR_LIMIT=3)
//  1. Reset:
//       RST=1 for 2 edges mid-sequence -> state=00, locked=0, expected=0, error_count=0, wrap_count=0.
//  2. Lock:
//       valid 3,4,5 on consecutive cycles -> SYNC after 3; LOCKED and locked=1 after 4; expected=6 after 5; no error_pulse.
//  3. Wrap:
//       locked, feed 6..15 then 0 -> wrap_count=1 after the 15 sample, expected=1, error_count=0.
//  4. Single glitch:
//       locked expecting 5, feed 9 -> error_pulse for 1 cycle, error_count=1, state=SLIP, expected=6.
//       Then feed 6 -> LOCKED, expected=7.
//  5. Lock loss:
//       locked expecting 2, feed 9,9,9 -> 3 error pulses, error_count=3, HUNT after the 3rd, locked=0.
//       Then feed 0,1 -> relocks.
//  6. Gaps and clear:
//       count_valid=0 for 5 cycles while locked -> all outputs hold, no pulse.
//       Then clear_stats=1 in the same cycle as a matched 15 -> wrap_count=0, error_count=0, state LOCKED.

Source files
------------

// File: rtl/mod16_sequence_checker.sv
// Receive-side monitor for a free-running mod-2^WIDTH counter: locks onto the
// +1 sequence, flywheels through glitches, and keeps error / wrap statistics.
module mod16_sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_LIMIT  = 3,
    parameter int WRAP_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clear_stats,
    output logic              locked,
    output logic [1:0]        state,
    output logic [WIDTH-1:0]  expected,
    output logic              error_pulse,
    output logic [7:0]        error_count,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam int MC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int EL_W = (ERR_LIMIT  < 2) ? 1 : $clog2(ERR_LIMIT + 1);

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [MC_W-1:0]   MC_ONE   = MC_W'(1);
    localparam logic [MC_W-1:0]   LOCK_N   = MC_W'(LOCK_COUNT);
    localparam logic [EL_W-1:0]   EL_ONE   = EL_W'(1);
    localparam logic [EL_W-1:0]   ERR_N    = EL_W'(ERR_LIMIT);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10,
        SLIP   = 2'b11
    } fsm_t;

    fsm_t            st;
    logic [MC_W-1:0] match_cnt;
    logic [EL_W-1:0] miss_cnt;

    logic hit, in_lock, err_inc, wrap_inc;

    always_comb begin
        hit      = count_valid && (count_in == expected);
        in_lock  = (st == LOCKED) || (st == SLIP);
        err_inc  = in_lock && count_valid && !hit;
        wrap_inc = in_lock && hit && (&count_in);
    end

    assign state = st;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st          <= HUNT;
            locked      <= 1'b0;
            expected    <= '0;
            error_pulse <= 1'b0;
            error_count <= '0;
            wrap_count  <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
        end else begin
            error_pulse <= err_inc;

            if (count_valid) begin
                case (st)
                    HUNT: begin
                        expected  <= count_in + CNT_ONE;
                        match_cnt <= MC_ONE;
                        if (LOCK_COUNT == 1) begin
                            st     <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            st <= SYNC;
                        end
                    end
                    SYNC: begin
                        // a mismatch simply reseeds the prediction; nothing is flagged
                        expected <= count_in + CNT_ONE;
                        if (hit) begin
                            match_cnt <= match_cnt + MC_ONE;
                            if (match_cnt + MC_ONE == LOCK_N) begin
                                st     <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= MC_ONE;
                        end
                    end
                    LOCKED: begin
                        expected <= expected + CNT_ONE;
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= EL_ONE;
                            if (ERR_LIMIT == 1) begin
                                st     <= HUNT;
                                locked <= 1'b0;
                            end else begin
                                st <= SLIP;
                            end
                        end
                    end
                    SLIP: begin
                        expected <= expected + CNT_ONE;
                        if (hit) begin
                            st       <= LOCKED;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + EL_ONE;
                            if (miss_cnt + EL_ONE == ERR_N) begin
                                st     <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: st <= HUNT;
                endcase
            end

            // clear takes priority over a same-cycle increment
            if (clear_stats)
                error_count <= '0;
            else if (err_inc && error_count != 8'hFF)
                error_count <= error_count + 8'd1;

            if (clear_stats)
                wrap_count <= '0;
            else if (wrap_inc)
                wrap_count <= wrap_count + WRAP_ONE;
        end
    end

endmodule
